mem_bus_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 6502 system memory/I/O bus. It shares the single downstream bus between the CPU port (port 0) and a DMA/loader port (port 1). For each granted transfer it classifies the address into a memory-map region and inserts that region's wait states, then returns read data and a one-cycle acknowledge. It sits between the requesters and the RAM/ROM/I/O read-data mux.

---
 rtl/mem_bus_arbiter_pkg.sv | 45 ++++
 rtl/mem_region_wait.sv | 30 +++
 rtl/mem_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-map constants, FSM encodings and bus payload type for the 6502 bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned REGION_W = 2;
    localparam int unsigned HI_W     = 3;

    localparam logic [REGION_W-1:0] REG_RAM   = 2'd0;
    localparam logic [REGION_W-1:0] REG_BASIC = 2'd1;
    localparam logic [REGION_W-1:0] REG_IO    = 2'd2;
    localparam logic [REGION_W-1:0] REG_MON   = 2'd3;

    localparam logic [ADDR_W-1:0] BASE_RAM     = 16'h0000;
    localparam logic [ADDR_W-1:0] BASE_BASIC   = 16'h8000;
    localparam logic [ADDR_W-1:0] BASE_IO      = 16'hC000;
    localparam logic [ADDR_W-1:0] BASE_IO_RSVD = 16'hC300;
    localparam logic [ADDR_W-1:0] BASE_MON     = 16'hE000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // Region decode from the top three address bits; reserved I/O falls in REG_IO.
    function automatic logic [REGION_W-1:0] region_of(input logic [HI_W-1:0] hi);
        logic [REGION_W-1:0] r;
        r = REG_MON;
        casez (hi)
            3'b0??:  r = REG_RAM;
            3'b10?:  r = REG_BASIC;
            3'b110:  r = REG_IO;
            default: r = REG_MON;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_region_wait.sv
// Combinational address-to-{region, wait count} lookup; reusable by any bus master.
module mem_region_wait
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned WS_RAM   = 0,
    parameter int unsigned WS_BASIC = 1,
    parameter int unsigned WS_IO    = 2,
    parameter int unsigned WS_MON   = 1,
    parameter int unsigned CNT_W    = 3
) (
    input  logic [HI_W-1:0]     i_addr_hi,
    output logic [REGION_W-1:0] o_region_c,
    output logic [CNT_W-1:0]    o_wait_c
);

    logic [REGION_W-1:0] w_region;

    always_comb begin
        w_region   = region_of(i_addr_hi);
        o_region_c = w_region;
        o_wait_c   = CNT_W'(WS_MON);
        case (w_region)
            REG_RAM:   o_wait_c = CNT_W'(WS_RAM);
            REG_BASIC: o_wait_c = CNT_W'(WS_BASIC);
            REG_IO:    o_wait_c = CNT_W'(WS_IO);
            default:   o_wait_c = CNT_W'(WS_MON);
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port (CPU / DMA) arbiter and wait-state sequencer for the 6502 memory/I/O bus.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed CPU priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned WS_RAM   = 0,
    parameter int unsigned WS_BASIC = 1,
    parameter int unsigned WS_IO    = 2,
    parameter int unsigned WS_MON   = 1,
    parameter int unsigned CNT_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [1:0]          we,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic [DATA_W-1:0]   wdata1,
    output logic [1:0]          ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                bus_en,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_we,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [REGION_W-1:0] bus_region,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                grant_id
);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [1:0]          r_ack, w_ack_nxt;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
    logic                r_bus_en, w_bus_en_nxt;
    logic [ADDR_W-1:0]   r_bus_addr, w_bus_addr_nxt;
    logic                r_bus_we, w_bus_we_nxt;
    logic [DATA_W-1:0]   r_bus_wdata, w_bus_wdata_nxt;
    logic [REGION_W-1:0] r_bus_region, w_bus_region_nxt;
    logic                r_grant_id, w_grant_id_nxt;

    logic                w_win;
    bus_req_t            w_sel;
    logic [REGION_W-1:0] w_region;
    logic [CNT_W-1:0]    w_wait;

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer holds the last winner; reset to 1 so the CPU wins the first contention.
    logic r_ptr, w_ptr_nxt;

    always_comb begin
        w_win = (req == 2'b11) ? ~r_ptr : req[1];
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if ((r_state == ST_IDLE) && (req != 2'b00)) begin
            w_ptr_nxt = w_win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b1;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    always_comb begin
        w_win = ~req[0];
    end
`endif

    always_comb begin
        w_sel = w_win ? bus_req_t'{addr: addr1, we: we[1], wdata: wdata1}
                      : bus_req_t'{addr: addr0, we: we[0], wdata: wdata0};
    end

    mem_region_wait #(
        .WS_RAM   (WS_RAM),
        .WS_BASIC (WS_BASIC),
        .WS_IO    (WS_IO),
        .WS_MON   (WS_MON),
        .CNT_W    (CNT_W)
    ) u_region_wait (
        .i_addr_hi  (w_sel.addr[ADDR_W-1:ADDR_W-HI_W]),
        .o_region_c (w_region),
        .o_wait_c   (w_wait)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_ack_nxt        = 2'b00;
        w_rdata_nxt      = r_rdata;
        w_bus_en_nxt     = r_bus_en;
        w_bus_addr_nxt   = r_bus_addr;
        w_bus_we_nxt     = r_bus_we;
        w_bus_wdata_nxt  = r_bus_wdata;
        w_bus_region_nxt = r_bus_region;
        w_grant_id_nxt   = r_grant_id;

        case (r_state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    w_state_nxt      = ST_ACCESS;
                    w_bus_en_nxt     = 1'b1;
                    w_bus_addr_nxt   = w_sel.addr;
                    w_bus_we_nxt     = w_sel.we;
                    w_bus_wdata_nxt  = w_sel.wdata;
                    w_bus_region_nxt = w_region;
                    w_grant_id_nxt   = w_win;
                    w_cnt_nxt        = w_wait;
                end
            end
            ST_ACCESS: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    if (!r_bus_we) begin
                        w_rdata_nxt = bus_rdata;
                    end
                    w_bus_en_nxt = 1'b0;
                    w_bus_we_nxt = 1'b0;
                    w_ack_nxt    = r_grant_id ? 2'b10 : 2'b01;
                    w_state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_ack        <= 2'b00;
            r_rdata      <= '0;
            r_bus_en     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_we     <= 1'b0;
            r_bus_wdata  <= '0;
            r_bus_region <= REG_RAM;
            r_grant_id   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ack        <= w_ack_nxt;
            r_rdata      <= w_rdata_nxt;
            r_bus_en     <= w_bus_en_nxt;
            r_bus_addr   <= w_bus_addr_nxt;
            r_bus_we     <= w_bus_we_nxt;
            r_bus_wdata  <= w_bus_wdata_nxt;
            r_bus_region <= w_bus_region_nxt;
            r_grant_id   <= w_grant_id_nxt;
        end
    end

    assign ack        = r_ack;
    assign rdata      = r_rdata;
    assign bus_en     = r_bus_en;
    assign bus_addr   = r_bus_addr;
    assign bus_we     = r_bus_we;
    assign bus_wdata  = r_bus_wdata;
    assign bus_region = r_bus_region;
    assign grant_id   = r_grant_id;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter (default wait states 0/1/2/1).
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] addr0, addr1;
    logic [1:0]  we;
    logic [7:0]  wdata0, wdata1;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic        bus_en;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_wdata;
    logic [1:0]  bus_region;
    logic [7:0]  bus_rdata;
    logic        grant_id;

    int n_pass;
    int n_total;

    mem_bus_arbiter u_dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .addr0      (addr0),
        .addr1      (addr1),
        .we         (we),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .ack        (ack),
        .rdata      (rdata),
        .bus_en     (bus_en),
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .bus_wdata  (bus_wdata),
        .bus_region (bus_region),
        .bus_rdata  (bus_rdata),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        logic [1:0]  exp_region;
        int          exp_lat;
        logic [7:0]  exp_rdata;
    } vec_t;

    typedef struct {
        int          lat;
        int          en_cyc;
        logic [1:0]  region;
        logic [1:0]  ack_v;
        logic        we_v;
        logic [7:0]  wdata_v;
        logic [7:0]  rdata_v;
        logic [15:0] addr_v;
    } obs_t;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // One transfer on one port; observes grant-cycle outputs, ack latency and bus_en length.
    task automatic xfer(input logic p, input logic [15:0] a, input logic w, input logic [7:0] wd,
                        input logic [7:0] rd, input logic drop_early, output obs_t o);
        @(negedge clk);
        if (p) begin addr1 = a; we[1] = w; wdata1 = wd; end
        else   begin addr0 = a; we[0] = w; wdata0 = wd; end
        bus_rdata = rd;
        req = p ? 2'b10 : 2'b01;
        o.lat = -1; o.en_cyc = 0; o.region = 2'bxx; o.ack_v = 2'b00;
        o.we_v = 1'bx; o.wdata_v = 8'hxx; o.rdata_v = 8'hxx; o.addr_v = 16'hxxxx;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin
                o.region = bus_region; o.addr_v = bus_addr; o.we_v = bus_we; o.wdata_v = bus_wdata;
                if (drop_early) req = 2'b00;
            end
            if (bus_en) o.en_cyc++;
            if (ack != 2'b00 && o.lat < 0) begin
                o.lat = k; o.ack_v = ack; o.rdata_v = rdata; req = 2'b00;
            end
            if (o.lat > 0 && k == o.lat + 2) break;
        end
        req = 2'b00;
    endtask

    vec_t vecs[11];
    obs_t ob;
    logic        g[4];
    int          t[4];
    int          n_g;
    logic        prev_en;
    logic        ack_seen;
    logic        exp_g[4];
    int          lat2;
    logic [7:0]  rd2;

    initial begin
        vecs[0]  = '{1'b0, 16'h1234, 1'b0, 8'h00, 8'hA5, 2'd0, 2, 8'hA5};
        vecs[1]  = '{1'b1, 16'hC001, 1'b1, 8'h3C, 8'h77, 2'd2, 4, 8'hA5};
        vecs[2]  = '{1'b0, 16'h7FFF, 1'b0, 8'h00, 8'h11, 2'd0, 2, 8'h11};
        vecs[3]  = '{1'b0, 16'h8000, 1'b0, 8'h00, 8'h22, 2'd1, 3, 8'h22};
        vecs[4]  = '{1'b0, 16'hBFFF, 1'b0, 8'h00, 8'h33, 2'd1, 3, 8'h33};
        vecs[5]  = '{1'b0, 16'hC000, 1'b0, 8'h00, 8'h44, 2'd2, 4, 8'h44};
        vecs[6]  = '{1'b0, 16'hDFFF, 1'b0, 8'h00, 8'h55, 2'd2, 4, 8'h55};
        vecs[7]  = '{1'b0, 16'hE000, 1'b0, 8'h00, 8'h66, 2'd3, 3, 8'h66};
        vecs[8]  = '{1'b0, 16'hFFFF, 1'b0, 8'h00, 8'h77, 2'd3, 3, 8'h77};
        vecs[9]  = '{1'b1, 16'hC300, 1'b0, 8'h00, 8'h5A, 2'd2, 4, 8'h5A};
        vecs[10] = '{1'b1, 16'h0010, 1'b1, 8'h99, 8'h00, 2'd0, 2, 8'h5A};

`ifdef ARB_ROUND_ROBIN_EN
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
`else
        exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0; exp_g[3] = 1'b0;
`endif

        n_pass = 0; n_total = 0;
        rst = 1'b1; req = 2'b00; we = 2'b00;
        addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 8'h00; wdata1 = 8'h00; bus_rdata = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst_ack",        32'(ack),        32'h0);
        chk("rst_bus_en",     32'(bus_en),     32'h0);
        chk("rst_bus_we",     32'(bus_we),     32'h0);
        chk("rst_rdata",      32'(rdata),      32'h0);
        chk("rst_bus_addr",   32'(bus_addr),   32'h0);
        chk("rst_bus_wdata",  32'(bus_wdata),  32'h0);
        chk("rst_bus_region", 32'(bus_region), 32'h0);
        chk("rst_grant_id",   32'(grant_id),   32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Contention: both ports held requesting RAM addresses.
        addr0 = 16'h0100; addr1 = 16'h0200; we = 2'b00;
        req = 2'b11;
        n_g = 0; prev_en = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus_en && !prev_en && n_g < 4) begin
                g[n_g] = grant_id; t[n_g] = k; n_g++;
            end
            prev_en = bus_en;
            if (n_g == 4) break;
        end
        req = 2'b00;
        repeat (5) @(negedge clk);
        chk("cont_grants", 32'(n_g), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < n_g) begin
                chk($sformatf("cont_grant%0d", i), 32'(g[i]), 32'(exp_g[i]));
                if (i > 0) chk($sformatf("cont_period%0d", i), 32'(t[i] - t[i-1]), 32'd3);
            end
        end

        // Single transfers: region decode, latency, bus_en length, ack port, rdata.
        for (int i = 0; i < 11; i++) begin
            xfer(vecs[i].port, vecs[i].addr, vecs[i].wr, vecs[i].wd, vecs[i].rd, 1'b0, ob);
            chk($sformatf("v%0d_addr", i),   32'(ob.addr_v), 32'(vecs[i].addr));
            chk($sformatf("v%0d_region", i), 32'(ob.region), 32'(vecs[i].exp_region));
            chk($sformatf("v%0d_we", i),     32'(ob.we_v),   32'(vecs[i].wr));
            chk($sformatf("v%0d_lat", i),    32'(ob.lat),    32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_en_cyc", i), 32'(ob.en_cyc), 32'(vecs[i].exp_lat - 1));
            chk($sformatf("v%0d_ack", i),    32'(ob.ack_v),  vecs[i].port ? 32'h2 : 32'h1);
            chk($sformatf("v%0d_rdata", i),  32'(ob.rdata_v), 32'(vecs[i].exp_rdata));
            if (vecs[i].wr) chk($sformatf("v%0d_wdata", i), 32'(ob.wdata_v), 32'(vecs[i].wd));
        end

        // Request dropped right after grant of an I/O read: still acks once, no second transfer.
        xfer(1'b0, 16'hC010, 1'b0, 8'h00, 8'hC3, 1'b1, ob);
        chk("drop_lat",    32'(ob.lat),     32'd4);
        chk("drop_en_cyc", 32'(ob.en_cyc),  32'd3);
        chk("drop_ack",    32'(ob.ack_v),   32'h1);
        chk("drop_rdata",  32'(ob.rdata_v), 32'hC3);

        // Reset in the second ACCESS cycle of a monitor-ROM read.
        @(negedge clk);
        addr0 = 16'hE000; we[0] = 1'b0; bus_rdata = 8'hEE; req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        chk("mid_bus_en_pre", 32'(bus_en), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_bus_en",   32'(bus_en),     32'h0);
        chk("mid_ack",      32'(ack),        32'h0);
        chk("mid_bus_addr", 32'(bus_addr),   32'h0);
        chk("mid_region",   32'(bus_region), 32'h0);
        chk("mid_rdata",    32'(rdata),      32'h0);
        ack_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ack != 2'b00) ack_seen = 1'b1;
        end
        chk("mid_no_ack", 32'(ack_seen), 32'h0);
        addr0 = 16'h0040; bus_rdata = 8'h4D;
        rst = 1'b0;
        lat2 = -1; rd2 = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ack != 2'b00 && lat2 < 0) begin
                lat2 = k; rd2 = rdata; req = 2'b00;
            end
        end
        req = 2'b00;
        chk("post_rst_lat",   32'(lat2), 32'd2);
        chk("post_rst_rdata", 32'(rd2),  32'h4D);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
